red_pitaya_sys_arb: RTL and testbench

Two-master arbiter that shares one system-bus slave (the housekeeping register bank, `red_pitaya_hk`) between two requesters, e.g. the PS bus bridge and an internal register sequencer. Each master issues single-cycle strobes. The arbiter captures each master's request, grants the slave round-robin, and serialises exactly one outstanding slave transaction at a time. A timeout guarantees every accepted request gets a response, even if the slave never acknowledges.

---
 rtl/red_pitaya_sys_arb_pkg.sv | 32 +++
 rtl/red_pitaya_sys_req_latch.sv | 42 ++++
 rtl/red_pitaya_sys_arb.sv | 186 ++++++++++++++++++
 tb/tb_red_pitaya_sys_arb.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_sys_arb_pkg.sv
// Shared types for the two-master system-bus arbiter: FSM state, latched request
// record and the round-robin pick used when both masters are pending.
package red_pitaya_sys_arb_pkg;

    localparam int SYS_AW = 32;
    localparam int SYS_DW = 32;
    localparam int SYS_SW = SYS_DW / 8;
    localparam int TMO_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic [SYS_AW-1:0] addr;
        logic [SYS_DW-1:0] wdata;
        logic [SYS_SW-1:0] sel;
        logic              wr;
    } sys_req_t;

    // A lone requester always wins; on a tie the master that was not granted last wins.
    function automatic logic rr_pick(input logic pend0, input logic pend1, input logic last);
        if (pend0 && pend1) begin
            return ~last;
        end
        return pend1;
    endfunction

endpackage

// File: rtl/red_pitaya_sys_req_latch.sv
// Per-master single-entry request holder: strobe captured in 1 cycle, pend held until clr.
// No backpressure: a strobe while pend is set is dropped and flagged in sticky ovf.
module red_pitaya_sys_req_latch
    import red_pitaya_sys_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wen,
    input  logic              ren,
    input  logic [SYS_AW-1:0] addr,
    input  logic [SYS_DW-1:0] wdata,
    input  logic [SYS_SW-1:0] sel,
    input  logic              clr,
    output sys_req_t          req,
    output logic              pend,
    output logic              ovf
);

    logic strobe;

    assign strobe = wen | ren;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req  <= '0;
            pend <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            // pend is still set during the ack cycle, so a strobe there is an overflow too
            if (strobe && pend) begin
                ovf <= 1'b1;
            end
            if (clr) begin
                pend <= 1'b0;
            end else if (strobe && !pend) begin
                req  <= '{addr, wdata, sel, wen};
                pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/red_pitaya_sys_arb.sv
// Round-robin arbiter sharing one system-bus slave between two masters, one transaction at a time.
// Latency strobe->ack 3 cycles minimum; no backpressure, overlapping strobes are dropped (ovf), TMO bounds slave wait.
module red_pitaya_sys_arb
    import red_pitaya_sys_arb_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_sel,
    input  logic            m0_wen,
    input  logic            m0_ren,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_ack,
    output logic            m0_err,
    output logic            m0_ovf,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_sel,
    input  logic            m1_wen,
    input  logic            m1_ren,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_ack,
    output logic            m1_err,
    output logic            m1_ovf,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_sel,
    output logic            s_wen,
    output logic            s_ren,
    input  logic [DW-1:0]   s_rdata,
    input  logic            s_ack,
    input  logic            s_err
);

    localparam int               SW    = DW / 8;
    localparam logic [TMO_W-1:0] TMO_C = TMO_W'(TMO);

    arb_state_t       state;
    arb_state_t       state_nxt;
    sys_req_t         req0;
    sys_req_t         req1;
    sys_req_t         new_req;
    logic             pend0;
    logic             pend1;
    logic             grant;
    logic             grant_nxt;
    logic             gnt_wr;
    logic             last;
    logic [TMO_W-1:0] cnt;
    logic [DW-1:0]    resp_rdata;
    logic             resp_err;
    logic             take;
    logic             cap_ack;
    logic             cap_tmo;
    logic             cnt_inc;

    red_pitaya_sys_req_latch u_latch0 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .wen   (m0_wen),
        .ren   (m0_ren),
        .addr  (SYS_AW'(m0_addr)),
        .wdata (SYS_DW'(m0_wdata)),
        .sel   (SYS_SW'(m0_sel)),
        .clr   (m0_ack),
        .req   (req0),
        .pend  (pend0),
        .ovf   (m0_ovf)
    );

    red_pitaya_sys_req_latch u_latch1 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .wen   (m1_wen),
        .ren   (m1_ren),
        .addr  (SYS_AW'(m1_addr)),
        .wdata (SYS_DW'(m1_wdata)),
        .sel   (SYS_SW'(m1_sel)),
        .clr   (m1_ack),
        .req   (req1),
        .pend  (pend1),
        .ovf   (m1_ovf)
    );

    assign grant_nxt = rr_pick(pend0, pend1, last);
    assign new_req   = grant_nxt ? req1 : req0;

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        cap_ack   = 1'b0;
        cap_tmo   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (pend0 || pend1) begin
                    state_nxt = ISSUE;
                    take      = 1'b1;
                end
            end
            ISSUE: begin
                if (s_ack) begin
                    state_nxt = RESP;
                    cap_ack   = 1'b1;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (s_ack) begin
                    state_nxt = RESP;
                    cap_ack   = 1'b1;
                end else if (cnt >= TMO_C) begin
                    state_nxt = RESP;
                    cap_tmo   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            grant      <= 1'b0;
            gnt_wr     <= 1'b0;
            last       <= 1'b1;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_sel      <= '0;
            s_wen      <= 1'b0;
            s_ren      <= 1'b0;
        end else begin
            state <= state_nxt;
            s_wen <= 1'b0;
            s_ren <= 1'b0;
            if (take) begin
                grant   <= grant_nxt;
                last    <= grant_nxt;
                gnt_wr  <= new_req.wr;
                s_addr  <= AW'(new_req.addr);
                s_wdata <= DW'(new_req.wdata);
                s_sel   <= SW'(new_req.sel);
                s_wen   <= new_req.wr;
                s_ren   <= ~new_req.wr;
            end
            // The counter counts cycles since the slave strobe; ISSUE is cycle 0.
            if (state == ISSUE) begin
                cnt <= TMO_W'(1);
            end else if (cnt_inc) begin
                cnt <= cnt + TMO_W'(1);
            end
            if (cap_ack) begin
                resp_rdata <= gnt_wr ? '0 : s_rdata;
                resp_err   <= s_err;
            end else if (cap_tmo) begin
                resp_rdata <= '0;
                resp_err   <= 1'b1;
            end
        end
    end

    // Responses exist only in RESP, so an ack seen in IDLE or RESP never reaches a master.
    assign m0_ack   = (state == RESP) && !grant;
    assign m1_ack   = (state == RESP) && grant;
    assign m0_err   = m0_ack & resp_err;
    assign m1_err   = m1_ack & resp_err;
    assign m0_rdata = m0_ack ? resp_rdata : '0;
    assign m1_rdata = m1_ack ? resp_rdata : '0;

endmodule

// File: tb/tb_red_pitaya_sys_arb.sv
// Scoreboard bench for red_pitaya_sys_arb: expected responses queued per master at strobe time,
// popped and compared when the master ack appears; a behavioural slave answers with a set delay.
module tb_red_pitaya_sys_arb;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        wr;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic [3:0]    m0_sel = '0, m1_sel = '0;
    logic          m0_wen = 1'b0, m0_ren = 1'b0, m1_wen = 1'b0, m1_ren = 1'b0;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_ack, m1_ack, m0_err, m1_err, m0_ovf, m1_ovf;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [3:0]    s_sel;
    logic          s_wen, s_ren;
    logic [DW-1:0] s_rdata;
    logic          s_ack, s_err;

    red_pitaya_sys_arb #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_sel   (m0_sel),
        .m0_wen   (m0_wen),
        .m0_ren   (m0_ren),
        .m0_rdata (m0_rdata),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m0_ovf   (m0_ovf),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_sel   (m1_sel),
        .m1_wen   (m1_wen),
        .m1_ren   (m1_ren),
        .m1_rdata (m1_rdata),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .m1_ovf   (m1_ovf),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_sel    (s_sel),
        .s_wen    (s_wen),
        .s_ren    (s_ren),
        .s_rdata  (s_rdata),
        .s_ack    (s_ack),
        .s_err    (s_err)
    );

    always #5 clk_i = ~clk_i;

    int   cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   grant_log[$];
    int   stb_log[$];
    int   ack_dly = 1;
    int   late_req = 0;
    int   late_done = 0;
    int   ack_cnt = -1;
    int   n_ack0 = 0, n_ack1 = 0, n_wen = 0, n_ren = 0;
    int   ack_cyc0 = 0, ack_cyc1 = 0, stb_cyc = 0;
    logic [31:0] last_rd1 = '0;
    logic [31:0] rsp_rdata = '0;
    logic        rsp_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] slave_rd(input logic [31:0] addr);
        return (addr == 32'h0) ? 32'hDEAD_BEEF : (addr ^ 32'h5A5A_0000);
    endfunction

    task automatic sync();
        @(posedge clk_i);
        #1;
    endtask

    // Drive a master strobe; a response is expected only if the master has nothing outstanding.
    task automatic set_req(input int m, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] sel);
        exp_t e;
        e.addr  = addr;
        e.wdata = wdata;
        e.sel   = sel;
        e.wr    = wr;
        if (ack_dly < 0) begin
            e.rdata = '0;
            e.err   = 1'b1;
        end else begin
            e.rdata = wr ? 32'h0 : slave_rd(addr);
            e.err   = addr[31];
        end
        if (m == 0) begin
            m0_addr = addr; m0_wdata = wdata; m0_sel = sel; m0_wen = wr; m0_ren = !wr;
            if (exp_q0.size() == 0) exp_q0.push_back(e);
        end else begin
            m1_addr = addr; m1_wdata = wdata; m1_sel = sel; m1_wen = wr; m1_ren = !wr;
            if (exp_q1.size() == 0) exp_q1.push_back(e);
        end
    endtask

    task automatic pulse();
        sync();
        m0_wen = 1'b0; m0_ren = 1'b0; m1_wen = 1'b0; m1_ren = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        chk(tag, 64'(exp_q0.size() + exp_q1.size()), 0);
        exp_q0.delete();
        exp_q1.delete();
        sync();
    endtask

    // Monitor and behavioural slave, both sampling on the falling edge.
    initial begin : mon
        exp_t e;
        int   m;
        s_ack = 1'b0; s_rdata = '0; s_err = 1'b0;
        forever begin
            @(negedge clk_i);
            s_ack = 1'b0; s_rdata = '0; s_err = 1'b0;
            if (m0_ack === 1'b1) begin
                n_ack0++;
                ack_cyc0 = cyc;
                if (exp_q0.size() == 0) chk("m0_spurious_ack", 1, 0);
                else begin
                    e = exp_q0.pop_front();
                    chk("m0_rdata", m0_rdata, e.rdata);
                    chk("m0_err", m0_err, e.err);
                end
            end
            if (m1_ack === 1'b1) begin
                n_ack1++;
                ack_cyc1 = cyc;
                last_rd1 = m1_rdata;
                if (exp_q1.size() == 0) chk("m1_spurious_ack", 1, 0);
                else begin
                    e = exp_q1.pop_front();
                    chk("m1_rdata", m1_rdata, e.rdata);
                    chk("m1_err", m1_err, e.err);
                end
            end
            if (s_wen === 1'b1 || s_ren === 1'b1) begin
                n_wen += int'(s_wen);
                n_ren += int'(s_ren);
                stb_cyc = cyc;
                m = -1;
                if (exp_q0.size() != 0 && exp_q0[0].addr == s_addr) m = 0;
                else if (exp_q1.size() != 0 && exp_q1[0].addr == s_addr) m = 1;
                chk("s_route", 64'(m >= 0), 1);
                if (m >= 0) begin
                    e = (m == 0) ? exp_q0[0] : exp_q1[0];
                    chk("s_wen", s_wen, e.wr);
                    chk("s_ren", s_ren, !e.wr);
                    chk("s_sel", s_sel, e.sel);
                    if (e.wr) chk("s_wdata", s_wdata, e.wdata);
                    grant_log.push_back(m);
                end
                stb_log.push_back(cyc);
                if (ack_dly >= 0) begin
                    ack_cnt   = ack_dly;
                    rsp_rdata = slave_rd(s_addr);
                    rsp_err   = s_addr[31];
                end
            end
            if (ack_cnt == 0) begin
                s_ack = 1'b1; s_rdata = rsp_rdata; s_err = rsp_err;
            end
            if (ack_cnt >= 0) ack_cnt--;
            if (late_req != late_done) begin
                s_ack = 1'b1; s_rdata = 32'hBAD0_BAD0; s_err = 1'b0;
                late_done++;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int t0, a0, a1, nw, nr, n;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_flags", {m0_ack, m1_ack, m0_err, m1_err, m0_ovf, m1_ovf, s_wen, s_ren}, 0);
        chk("rst_m_rdata", {m0_rdata, m1_rdata}, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_s_wdata", s_wdata, 0);
        chk("rst_s_sel", s_sel, 0);
        sync();
        rst_i = 1'b0;
        sync();

        // Simultaneous requests: m0 wins the first tie, then strict alternation
        ack_dly = 1;
        grant_log.delete();
        stb_log.delete();
        a0 = n_ack0; a1 = n_ack1;
        for (int r = 0; r < 4; r++) begin
            set_req(0, 1'b1, 32'h1000 + 32'(r * 4), 32'hA000 + 32'(r), 4'hF);
            set_req(1, 1'b0, 32'h2000 + 32'(r * 4), 32'h0, 4'h3);
            pulse();
            wait_drain(60, "contend_drain");
            if (r == 0) chk("loser_gap", 64'(stb_log[1] - ack_cyc0), 2);
        end
        chk("contend_cnt", 64'(grant_log.size()), 8);
        for (int i = 0; i < grant_log.size(); i++) chk("grant_order", 64'(grant_log[i]), 64'(i % 2));
        chk("contend_acks0", 64'(n_ack0 - a0), 4);
        chk("contend_acks1", 64'(n_ack1 - a1), 4);

        // m0 write 0x30/0x03, slave acks one cycle after its strobe
        ack_dly = 1;
        a1 = n_ack1;
        t0 = cyc;
        set_req(0, 1'b1, 32'h30, 32'h03, 4'hF);
        pulse();
        wait_drain(40, "wr_drain");
        chk("wr_stb_lat", 64'(stb_cyc - t0), 2);
        chk("wr_ack_lat", 64'(ack_cyc0 - t0), 4);
        chk("wr_no_m1_ack", 64'(n_ack1 - a1), 0);

        // m1 read of 0x00 returns 0xDEADBEEF, single-cycle s_ren
        ack_dly = 2;
        nr = n_ren;
        set_req(1, 1'b0, 32'h0, 32'h0, 4'hF);
        pulse();
        wait_drain(40, "rd_drain");
        chk("rd_ren_cycles", 64'(n_ren - nr), 1);
        chk("rd_data", last_rd1, 32'hDEAD_BEEF);

        // Minimum round trip: slave acks in its strobe cycle
        ack_dly = 0;
        t0 = cyc;
        set_req(0, 1'b0, 32'h44, 32'h0, 4'h1);
        pulse();
        wait_drain(40, "min_rt_drain");
        chk("min_rt_lat", 64'(ack_cyc0 - t0), 3);

        // Slave error on a write passes through with rdata 0
        ack_dly = 1;
        set_req(1, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'hC);
        pulse();
        wait_drain(40, "err_drain");

        // Timeout, then a late slave ack that must go nowhere
        ack_dly = -1;
        set_req(0, 1'b0, 32'h80, 32'h0, 4'hF);
        pulse();
        wait_drain(40, "tmo_drain");
        chk("tmo_lat", 64'(ack_cyc0 - stb_cyc), TMO + 1);
        a0 = n_ack0; a1 = n_ack1;
        late_req++;
        repeat (6) sync();
        chk("late_ack_m0", 64'(n_ack0 - a0), 0);
        chk("late_ack_m1", 64'(n_ack1 - a1), 0);

        // Second strobe while pending is dropped and sets sticky ovf
        ack_dly = 3;
        nw = n_wen;
        chk("ovf_pre", m0_ovf, 0);
        set_req(0, 1'b1, 32'h100, 32'h11, 4'hF);
        pulse();
        set_req(0, 1'b1, 32'h104, 32'h22, 4'hF);
        pulse();
        wait_drain(40, "ovf_drain");
        chk("ovf_wen_cnt", 64'(n_wen - nw), 1);
        chk("ovf_m0", m0_ovf, 1);
        chk("ovf_m1", m1_ovf, 0);
        ack_dly = 1;
        set_req(0, 1'b0, 32'h108, 32'h0, 4'hF);
        pulse();
        wait_drain(40, "ovf_after_drain");
        chk("ovf_sticky", m0_ovf, 1);

        // Reset while waiting on the slave discards the request
        ack_dly = -1;
        nr = n_ren;
        set_req(0, 1'b0, 32'h200, 32'h0, 4'hF);
        pulse();
        n = 0;
        while (n_ren == nr && n < 20) begin
            sync();
            n++;
        end
        chk("rm_issued", 64'(n_ren - nr), 1);
        repeat (2) sync();
        rst_i = 1'b1;
        exp_q0.delete();
        a0 = n_ack0;
        sync();
        @(negedge clk_i);
        chk("rm_flags", {m0_ack, m1_ack, m0_err, m1_err, m0_ovf, m1_ovf, s_wen, s_ren}, 0);
        chk("rm_m_rdata", {m0_rdata, m1_rdata}, 0);
        chk("rm_s_addr", s_addr, 0);
        chk("rm_s_wdata", s_wdata, 0);
        sync();
        rst_i = 1'b0;
        sync();
        ack_dly = 1;
        a1 = n_ack1;
        set_req(1, 1'b0, 32'h0C, 32'h0, 4'hF);
        pulse();
        wait_drain(40, "post_rst_drain");
        repeat (12) sync();
        chk("post_rst_m1_ack", 64'(n_ack1 - a1), 1);
        chk("post_rst_no_m0_ack", 64'(n_ack0 - a0), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
